// File: rtl/score_pkg.sv
// score_pkg: shared constants for the score counter.
//   state_t     - FSM state encodings (IDLE/PLAY/OVER; 2'd3 is unused)
//   BCD_DIG_MAX - largest legal BCD digit
//   SCORE_CLR   - value score/hiscore take on clear and round start
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIG_MAX = 4'd9;
    localparam logic [7:0] SCORE_CLR   = 8'h00;

endpackage

// File: rtl/bcd_inc.sv
// bcd_inc: combinational single-digit BCD incrementer.
//   d  - current digit (0..9)
//   ci - increment request / carry in
//   q  - next digit
//   co - carry out, set when a 9 wraps to 0
module bcd_inc
    import score_pkg::*;
(
    input  logic [3:0] d,
    input  logic       ci,
    output logic [3:0] q,
    output logic       co
);

    always_comb begin
        q  = d;
        co = 1'b0;
        if (ci) begin
            // >= also folds any stray non-BCD digit back to 0
            if (d >= BCD_DIG_MAX) begin
                q  = 4'd0;
                co = 1'b1;
            end else begin
                q  = d + 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_counter.sv
// score_counter: two-digit BCD game score with round FSM.
//   clk, clr    - clock, async active-high reset
//   game_start  - level; rising edge starts a round (from IDLE or OVER)
//   game_over   - level; ends the round while in PLAY
//   pass        - level; each rising edge in PLAY scores one point
//   score       - packed BCD {tens, units}, saturates at MAX_BCD
//   score_tick  - one-cycle pulse aligned with each new score value
//   state       - current FSM state
//   hiscore, new_record - only when SCORE_HISCORE_EN is defined
// Optional feature macro: SCORE_HISCORE_EN
module score_counter
    import score_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h99
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       pass,
    output logic [7:0] score,
    output logic       score_tick,
`ifdef SCORE_HISCORE_EN
    output logic [7:0] hiscore,
    output logic       new_record,
`endif
    output logic [1:0] state
);

    state_t     state_q, state_d;
    logic       game_start_q, pass_q;
    logic [7:0] score_q;
    logic       tick_q;

    logic       start_edge, pass_edge, round_start, inc_en;
    logic [3:0] units_n, tens_n;
    logic       units_co, tens_co;
    logic [7:0] score_inc;

    assign start_edge  = game_start & ~game_start_q;
    assign pass_edge   = pass & ~pass_q;
    assign round_start = start_edge && (state_q == ST_IDLE || state_q == ST_OVER);
    // game_over wins over a coincident pass edge; BCD values order like binary
    assign inc_en      = (state_q == ST_PLAY) && !game_over && pass_edge
                         && (score_q < MAX_BCD);

    bcd_inc u_units (.d(score_q[3:0]), .ci(inc_en),   .q(units_n), .co(units_co));
    bcd_inc u_tens  (.d(score_q[7:4]), .ci(units_co), .q(tens_n),  .co(tens_co));

    // never let a tens wrap reach the display, even if MAX_BCD is out of range
    assign score_inc = tens_co ? score_q : {tens_n, units_n};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_edge) state_d = ST_PLAY;
            ST_PLAY: if (game_over)  state_d = ST_OVER;
            ST_OVER: if (start_edge) state_d = ST_PLAY;
            default: state_d = ST_IDLE;
        endcase
    end

    // edge registers preload to 1 so inputs high at clr release are not edges
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            game_start_q <= 1'b1;
            pass_q       <= 1'b1;
            score_q      <= SCORE_CLR;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_start_q <= game_start;
            pass_q       <= pass;
            score_q      <= round_start ? SCORE_CLR : score_inc;
            tick_q       <= inc_en;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [7:0] hiscore_q;
    logic       new_record_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hiscore_q    <= SCORE_CLR;
            new_record_q <= 1'b0;
        end else if (round_start) begin
            new_record_q <= 1'b0;
        end else if (state_q == ST_PLAY && game_over && score_q > hiscore_q) begin
            hiscore_q    <= score_q;
            new_record_q <= 1'b1;
        end
    end

    assign hiscore    = hiscore_q;
    assign new_record = new_record_q;
`endif

    assign score      = score_q;
    assign score_tick = tick_q;
    assign state      = state_q;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: table-driven check of score_counter with an expected-value
// queue; hand-written sequences cover async clear and the hiscore option.
module tb_score_counter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       game_start = 1'b0;
    logic       game_over  = 1'b0;
    logic       pass       = 1'b0;
    logic [7:0] score;
    logic       score_tick;
    logic [1:0] state;
`ifdef SCORE_HISCORE_EN
    logic [7:0] hiscore;
    logic       new_record;
`endif

    always #5 clk = ~clk;

    score_counter #(.MAX_BCD(8'h99)) dut (
        .clk        (clk),
        .clr        (clr),
        .game_start (game_start),
        .game_over  (game_over),
        .pass       (pass),
        .score      (score),
        .score_tick (score_tick),
`ifdef SCORE_HISCORE_EN
        .hiscore    (hiscore),
        .new_record (new_record),
`endif
        .state      (state)
    );

    typedef struct {
        logic       gs;
        logic       go;
        logic       ps;
        logic [1:0] st;
        logic [7:0] sc;
        logic       tk;
    } vec_t;

    vec_t vtab[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, u;
        t = 4'((n / 10) % 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    task automatic add(input logic gs, go, ps, input logic [1:0] st,
                       input logic [7:0] sc, input logic tk);
        vec_t v;
        v.gs = gs; v.go = go; v.ps = ps; v.st = st; v.sc = sc; v.tk = tk;
        vtab.push_back(v);
    endtask

    task automatic check_out(input string nm);
        vec_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", nm);
            return;
        end
        e = exp_q.pop_front();
        if (state !== e.st) begin
            n_fail++;
            $display("FAIL %s state: got %0d want %0d", nm, state, e.st);
        end
        n_checks++;
        if (score !== e.sc) begin
            n_fail++;
            $display("FAIL %s score: got %h want %h", nm, score, e.sc);
        end
        n_checks++;
        if (score_tick !== e.tk) begin
            n_fail++;
            $display("FAIL %s tick: got %b want %b", nm, score_tick, e.tk);
        end
    endtask

    // drive on negedge, expect result after the next rising edge
    task automatic step(input string nm, input logic gs, go, ps,
                        input logic [1:0] st, input logic [7:0] sc, input logic tk);
        vec_t e;
        @(negedge clk);
        game_start = gs; game_over = go; pass = ps;
        e.gs = gs; e.go = go; e.ps = ps; e.st = st; e.sc = sc; e.tk = tk;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

`ifdef SCORE_HISCORE_EN
    task automatic check_hi(input string nm, input logic [7:0] hs, input logic nr);
        n_checks++;
        if (hiscore !== hs) begin
            n_fail++;
            $display("FAIL %s hiscore: got %h want %h", nm, hiscore, hs);
        end
        n_checks++;
        if (new_record !== nr) begin
            n_fail++;
            $display("FAIL %s new_record: got %b want %b", nm, new_record, nr);
        end
    endtask

    task automatic play_round(input string nm, input int pts);
        step(nm, 1, 0, 0, S_PLAY, 8'h00, 0);
        for (int i = 1; i <= pts; i++) begin
            step(nm, 0, 0, 1, S_PLAY, to_bcd(i), 1);
            step(nm, 0, 0, 0, S_PLAY, to_bcd(i), 0);
        end
        step(nm, 0, 1, 0, S_OVER, to_bcd(pts), 0);
        step(nm, 0, 0, 0, S_OVER, to_bcd(pts), 0);
    endtask
`endif

    initial begin
        vec_t e;

        // ---- table: leave IDLE, count 12, hold pass, over, saturation ----
        add(0, 0, 0, S_IDLE, 8'h00, 0);
        add(1, 0, 0, S_PLAY, 8'h00, 0);
        for (int i = 1; i <= 12; i++) begin
            add(0, 0, 1, S_PLAY, to_bcd(i), 1);
            add(0, 0, 0, S_PLAY, to_bcd(i), 0);
        end
        add(0, 0, 1, S_PLAY, 8'h13, 1);
        for (int i = 0; i < 49; i++) add(0, 0, 1, S_PLAY, 8'h13, 0);
        add(0, 0, 0, S_PLAY, 8'h13, 0);
        add(1, 0, 0, S_PLAY, 8'h13, 0);     // start edge ignored in PLAY
        add(0, 0, 0, S_PLAY, 8'h13, 0);
        add(0, 1, 0, S_OVER, 8'h13, 0);
        add(0, 0, 1, S_OVER, 8'h13, 0);     // no scoring in OVER
        add(0, 0, 0, S_OVER, 8'h13, 0);
        add(1, 0, 0, S_PLAY, 8'h00, 0);
        add(0, 0, 0, S_PLAY, 8'h00, 0);
        for (int i = 1; i <= 5; i++) begin
            add(0, 0, 1, S_PLAY, to_bcd(i), 1);
            add(0, 0, 0, S_PLAY, to_bcd(i), 0);
        end
        add(0, 1, 1, S_OVER, 8'h05, 0);     // game_over beats pass edge
        add(0, 0, 0, S_OVER, 8'h05, 0);
        add(1, 0, 0, S_PLAY, 8'h00, 0);
        add(0, 0, 0, S_PLAY, 8'h00, 0);
        for (int i = 1; i <= 99; i++) begin
            add(0, 0, 1, S_PLAY, to_bcd(i), 1);
            add(0, 0, 0, S_PLAY, to_bcd(i), 0);
        end
        add(0, 0, 1, S_PLAY, 8'h99, 0);     // saturated: no change, no tick
        add(0, 0, 0, S_PLAY, 8'h99, 0);
        add(0, 1, 0, S_OVER, 8'h99, 0);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        e.gs = 0; e.go = 0; e.ps = 0; e.st = S_IDLE; e.sc = 8'h00; e.tk = 0;
        exp_q.push_back(e);
        check_out("reset");
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < vtab.size(); i++)
            step($sformatf("vec%0d", i), vtab[i].gs, vtab[i].go, vtab[i].ps,
                 vtab[i].st, vtab[i].sc, vtab[i].tk);

        // ---- clr mid-round at 04 with pass held high ----
        step("clr_start", 1, 0, 0, S_PLAY, 8'h00, 0);
        for (int i = 1; i <= 4; i++) begin
            step("clr_cnt", 0, 0, 1, S_PLAY, to_bcd(i), 1);
            step("clr_cnt", 0, 0, 0, S_PLAY, to_bcd(i), 0);
        end
        @(negedge clk);
        pass = 1'b1; game_start = 1'b1; clr = 1'b1;
        #1;
        e.gs = 1; e.go = 0; e.ps = 1; e.st = S_IDLE; e.sc = 8'h00; e.tk = 0;
        exp_q.push_back(e);
        check_out("clr_async");
        @(negedge clk);
        clr = 1'b0;
        // inputs held high across release: no start, no tick
        for (int i = 0; i < 3; i++) step("clr_rel", 1, 0, 1, S_IDLE, 8'h00, 0);
        step("clr_gs_low", 0, 0, 1, S_IDLE, 8'h00, 0);
        // pass held high across PLAY entry does not count
        step("clr_restart", 1, 0, 1, S_PLAY, 8'h00, 0);
        step("clr_hold", 0, 0, 1, S_PLAY, 8'h00, 0);
        step("clr_pass", 0, 0, 0, S_PLAY, 8'h00, 0);
        step("clr_pass", 0, 0, 1, S_PLAY, 8'h01, 1);
        step("clr_end", 0, 1, 0, S_OVER, 8'h01, 0);

`ifdef SCORE_HISCORE_EN
        // reset hiscore and play two rounds: 07 then 03
        @(negedge clk);
        clr = 1'b1; game_start = 0; game_over = 0; pass = 0;
        #1;
        check_hi("hi_reset", 8'h00, 0);
        @(negedge clk);
        clr = 1'b0;
        step("hi_idle", 0, 0, 0, S_IDLE, 8'h00, 0);
        play_round("hi_r1", 7);
        check_hi("hi_r1", 8'h07, 1);
        step("hi_gap", 0, 0, 0, S_OVER, 8'h07, 0);
        play_round("hi_r2", 3);
        check_hi("hi_r2", 8'h07, 0);
`endif

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left over", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
